// File: rtl/line_buffer_loader.sv
// Writer-side front end for the line buffer: normalises each projection
// line to exactly pNoTaps*pTapsWidth shifts, then freezes and flags it.
module line_buffer_loader #(
    parameter int pDataLength  = 16,
    parameter int pNoTaps      = 4,
    parameter int pTapsWidth   = 8,
    parameter int pLineLength  = pNoTaps * pTapsWidth,
    parameter int pCountLength = $clog2(pLineLength + 1) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [pDataLength-1:0]  in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    lb_enable,
    output logic [pDataLength-1:0]  lb_shift_in,
    output logic                    line_ready,
    input  logic                    consume,
    output logic                    busy,
    output logic                    overflow,
    output logic [pCountLength-1:0] shift_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        FLUSH,
        DRAIN,
        READY
    } state_t;

    localparam logic [pCountLength-1:0] kLineLen =
        pCountLength'(pLineLength);

    state_t                  state;
    state_t                  state_d;
    logic                    en_d;
    logic [pDataLength-1:0]  data_d;
    logic [pCountLength-1:0] cnt_d;
    logic [pCountLength-1:0] cnt_inc;
    logic                    ovf_d;
    logic                    accept;

    assign in_ready   = (state == LOAD) || (state == DRAIN);
    assign busy       = (state != IDLE);
    assign line_ready = (state == READY);
    assign accept     = in_valid & in_ready;
    assign cnt_inc    = shift_count + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lb_enable   <= 1'b0;
            lb_shift_in <= '0;
            shift_count <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_d;
            lb_enable   <= en_d;
            lb_shift_in <= data_d;
            shift_count <= cnt_d;
            overflow    <= ovf_d;
        end
    end

    // FLUSH covers the cycle in which the final shift reaches the buffer,
    // so line_ready never coincides with an lb_enable pulse.
    always_comb begin
        state_d = state;
        en_d    = 1'b0;
        data_d  = lb_shift_in;
        cnt_d   = shift_count;
        ovf_d   = overflow;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    en_d   = 1'b1;
                    data_d = in_data;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == kLineLen) begin
                        if (in_last) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = DRAIN;
                            ovf_d   = 1'b1;
                        end
                    end else if (in_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                en_d   = 1'b1;
                data_d = '0;
                cnt_d  = cnt_inc;
                if (cnt_inc == kLineLen) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = READY;
            end
            DRAIN: begin
                if (accept && in_last) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (consume) begin
                    if (start) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_line_buffer_loader.sv
// Self-checking bench for line_buffer_loader with a shift-register model
// of the downstream line buffer.
module tb_line_buffer_loader;

    localparam int DW = 16;
    localparam int LL = 32;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          lb_enable;
    logic [DW-1:0] lb_shift_in;
    logic          line_ready;
    logic          consume;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] shift_count;

    line_buffer_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .lb_enable   (lb_enable),
        .lb_shift_in (lb_shift_in),
        .line_ready  (line_ready),
        .consume     (consume),
        .busy        (busy),
        .overflow    (overflow),
        .shift_count (shift_count)
    );

    always #5 clk = ~clk;

    // Line buffer: sr[0] is the newest sample, tap k sits at sr[8k].
    logic [DW-1:0] sr [LL];
    always @(posedge clk) begin
        if (lb_enable) begin
            for (int i = LL - 1; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= lb_shift_in;
        end
    end

    function automatic logic [4*DW-1:0] get_taps();
        return {sr[24], sr[16], sr[8], sr[0]};
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    logic ovf_exp = 1'b0;
    logic [DW-1:0] line_q [$];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"}, lb_enable, 0);
        check({tag, "_data"}, lb_shift_in, 0);
        check({tag, "_lr"}, line_ready, 0);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_cnt"}, shift_count, 0);
    endtask

    task automatic do_reset();
        reset = 1; start = 0; consume = 0;
        in_valid = 0; in_last = 0; in_data = '0;
        tick();
        reset = 0;
        ovf_exp = 1'b0;
        check_idle_outputs("reset");
    endtask

    function automatic logic valid_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 4 == 0) || (cyc % 4 == 3);
        return $urandom_range(0, 3) != 0;
    endfunction

    // Sends line_q and leaves the DUT in READY (not consumed).
    task automatic run_line(input int mode, input bit do_start);
        int len;
        int idx;
        int prev_idx;
        int cyc;
        int pulses;
        int bad;
        logic v;
        logic acc;
        logic prev_acc;
        logic prev_en;
        logic seen_last;
        logic done;
        logic [4*DW-1:0] taps;
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] got_q [$];
        len = line_q.size();
        for (int i = 0; i < LL; i++)
            exp_q.push_back(i < len ? line_q[i] : '0);
        ovf_exp = ovf_exp | (len > LL);
        if (do_start) begin
            start = 1;
            tick();
            start = 0;
        end
        check("load_rdy", in_ready, 1);
        check("load_cnt", shift_count, 0);
        idx = 0; prev_idx = 0; cyc = 0; pulses = 0;
        prev_acc = 0; prev_en = 0; seen_last = 0; done = 0;
        while (!done && cyc < 400) begin
            if (prev_acc && prev_idx < LL) begin
                check("lat_en", lb_enable, 1);
                check("lat_data", lb_shift_in, line_q[prev_idx]);
            end
            if (prev_acc && prev_idx >= LL)
                check("drain_en", lb_enable, 0);
            if (prev_acc && prev_idx == LL - 1 && len > LL)
                check("ovf_set", overflow, 1);
            if (lb_enable) begin
                pulses++;
                got_q.push_back(lb_shift_in);
            end
            if (line_ready) begin
                check("ready_no_en", lb_enable, 0);
                if (len <= LL)
                    check("ready_after_pulse", prev_en, 1);
                else
                    check("ready_after_last",
                          {prev_acc, prev_idx == len - 1}, 2'b11);
                done = 1;
            end else begin
                if (seen_last && len <= LL)
                    check("pad_rdy", in_ready, 0);
                v = (idx < len) && valid_pat(mode, cyc);
                in_valid = v;
                in_data = v ? line_q[idx] : DW'($urandom);
                in_last = v && (idx == len - 1);
                acc = v && in_ready;
                prev_en = lb_enable;
                tick();
                prev_acc = acc;
                prev_idx = idx;
                if (acc) begin
                    if (idx == len - 1) seen_last = 1;
                    idx++;
                end
                cyc++;
            end
        end
        in_valid = 0;
        in_last = 0;
        check("line_done", done, 1);
        check("pulses", pulses, LL);
        bad = 0;
        for (int i = 0; i < LL; i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        check("shift_seq_errs", bad, 0);
        taps = {exp_q[LL-25], exp_q[LL-17], exp_q[LL-9], exp_q[LL-1]};
        check("taps_model", get_taps(), taps);
        check("ready_cnt", shift_count, LL);
        check("ready_in_rdy", in_ready, 0);
        check("ready_busy", busy, 1);
        check("ready_ovf", overflow, ovf_exp);
        tick();
        tick();
        check("hold_lr", line_ready, 1);
        check("hold_en", lb_enable, 0);
        check("hold_taps", get_taps(), taps);
    endtask

    task automatic consume_line();
        consume = 1;
        tick();
        consume = 0;
        check("consume_lr", line_ready, 0);
        check("consume_busy", busy, 0);
    endtask

    task automatic ramp(input int len);
        line_q.delete();
        for (int i = 1; i <= len; i++) line_q.push_back(DW'(i));
    endtask

    typedef struct {
        int              len;
        int              mode;
        logic [4*DW-1:0] taps;
        logic            ovf;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{32, 0, {16'd8, 16'd16, 16'd24, 16'd32}, 1'b0};
        tbl[1] = '{20, 0, {16'd8, 16'd16, 16'd0,  16'd0 }, 1'b0};
        tbl[2] = '{40, 0, {16'd8, 16'd16, 16'd24, 16'd32}, 1'b1};
        tbl[3] = '{32, 1, {16'd8, 16'd16, 16'd24, 16'd32}, 1'b0};
        tbl[4] = '{1,  0, {16'd0, 16'd0,  16'd0,  16'd0 }, 1'b0};
        tbl[5] = '{25, 2, {16'd8, 16'd16, 16'd24, 16'd0 }, 1'b0};
        tbl[6] = '{33, 1, {16'd8, 16'd16, 16'd24, 16'd32}, 1'b1};

        do_reset();
        for (int t = 0; t < 7; t++) begin
            do_reset();
            ramp(tbl[t].len);
            run_line(tbl[t].mode, 1'b1);
            check("tbl_taps", get_taps(), tbl[t].taps);
            check("tbl_ovf", overflow, tbl[t].ovf);
            consume_line();
        end

        // overflow is sticky across later good lines
        ramp(32);
        run_line(0, 1'b1);
        check("ovf_sticky", overflow, 1);
        consume_line();

        // handover: consume and start together in READY
        do_reset();
        ramp(20);
        run_line(0, 1'b1);
        start = 1;
        consume = 1;
        tick();
        start = 0;
        consume = 0;
        check("hand_lr", line_ready, 0);
        check("hand_rdy", in_ready, 1);
        check("hand_cnt", shift_count, 0);
        check("hand_busy", busy, 1);
        check("hand_en", lb_enable, 0);
        ramp(32);
        run_line(0, 1'b0);
        check("hand_taps", get_taps(), {16'd8, 16'd16, 16'd24, 16'd32});
        consume_line();

        // consume alone in IDLE, and start/consume during LOAD
        consume = 1;
        tick();
        consume = 0;
        check("idle_consume_busy", busy, 0);
        start = 1;
        tick();
        consume = 1;
        tick();
        tick();
        start = 0;
        consume = 0;
        check("load_ign_rdy", in_ready, 1);
        check("load_ign_cnt", shift_count, 0);
        check("load_ign_lr", line_ready, 0);

        // reset after 10 accepts, then a fresh full line
        do_reset();
        start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1;
            in_data = DW'(i + 100);
            in_last = 0;
            tick();
        end
        check("mid_cnt", shift_count, 10);
        reset = 1;
        tick();
        reset = 0;
        in_valid = 0;
        check_idle_outputs("mid_reset");
        ovf_exp = 1'b0;
        ramp(32);
        run_line(0, 1'b1);
        check("mid_taps", get_taps(), {16'd8, 16'd16, 16'd24, 16'd32});
        consume_line();

        // random lines against the model
        for (int r = 0; r < 20; r++) begin
            int len;
            len = $urandom_range(1, 45);
            line_q.delete();
            for (int i = 0; i < len; i++)
                line_q.push_back(DW'($urandom_range(0, 65535)));
            run_line(2, 1'b1);
            consume_line();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
